// File: rtl/axi4_lite_master_engine.sv
// AXI4-Lite master engine: runs single-beat AW/W/B writes and AR/R reads for a command source.
// Latency: go -> done in 3 cycles against a zero-wait slave; response waits bounded by TIMEOUT.
// Backpressure: valids are held until their handshake; go strobes are dropped while o_busy is high.
module axi4_lite_master_engine #(
   parameter int ADDR_WIDTH = 7,
   parameter int TIMEOUT    = 255
) (
   input  logic                  i_axi_lite_aclk,
   input  logic                  i_axi_lite_aresetn,
   input  logic                  i_wr_go,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [31:0]           i_wr_data,
   input  logic [3:0]            i_wr_strb,
   input  logic                  i_rd_go,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic                  o_busy,
   output logic                  o_wr_done,
   output logic [1:0]            o_bresp,
   output logic                  o_rd_done,
   output logic [31:0]           o_rdata,
   output logic [1:0]            o_rresp,
   output logic                  o_timeout,
   output logic                  o_axi_lite_awvalid,
   input  logic                  i_axi_lite_awready,
   output logic [ADDR_WIDTH-1:0] o_axi_lite_awaddr,
   output logic                  o_axi_lite_wvalid,
   input  logic                  i_axi_lite_wready,
   output logic [31:0]           o_axi_lite_wdata,
   output logic [3:0]            o_axi_lite_wstrb,
   input  logic                  i_axi_lite_bvalid,
   output logic                  o_axi_lite_bready,
   input  logic [1:0]            i_axi_lite_bresp,
   output logic                  o_axi_lite_arvalid,
   input  logic                  i_axi_lite_arready,
   output logic [ADDR_WIDTH-1:0] o_axi_lite_araddr,
   input  logic                  i_axi_lite_rvalid,
   output logic                  o_axi_lite_rready,
   input  logic [31:0]           i_axi_lite_rdata,
   input  logic [1:0]            i_axi_lite_rresp
);

   typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RRESP} state_t;

   // Counter wide enough to hold TIMEOUT; abort fires on the cycle it would reach TIMEOUT.
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   state_t        state;
   logic          aw_done;
   logic          w_done;
   logic          rd_pend;
   logic [CW-1:0] wait_cnt;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs, to_hit, aw_fin, w_fin;

   // Handshake and timeout qualifiers used by the state machine.
   assign aw_hs  = o_axi_lite_awvalid & i_axi_lite_awready;
   assign w_hs   = o_axi_lite_wvalid & i_axi_lite_wready;
   assign b_hs   = o_axi_lite_bready & i_axi_lite_bvalid;
   assign ar_hs  = o_axi_lite_arvalid & i_axi_lite_arready;
   assign r_hs   = o_axi_lite_rready & i_axi_lite_rvalid;
   assign aw_fin = aw_done | aw_hs;
   assign w_fin  = w_done | w_hs;
   assign to_hit = (TIMEOUT != 0) && (wait_cnt == TO_LAST);

   // Transaction state machine; every output is registered here.
   always_ff @(posedge i_axi_lite_aclk or negedge i_axi_lite_aresetn) begin
      if (!i_axi_lite_aresetn) begin
         state              <= IDLE;
         aw_done            <= 1'b0;
         w_done             <= 1'b0;
         rd_pend            <= 1'b0;
         wait_cnt           <= '0;
         o_busy             <= 1'b0;
         o_wr_done          <= 1'b0;
         o_bresp            <= 2'b00;
         o_rd_done          <= 1'b0;
         o_rdata            <= 32'h0;
         o_rresp            <= 2'b00;
         o_timeout          <= 1'b0;
         o_axi_lite_awvalid <= 1'b0;
         o_axi_lite_awaddr  <= '0;
         o_axi_lite_wvalid  <= 1'b0;
         o_axi_lite_wdata   <= 32'h0;
         o_axi_lite_wstrb   <= 4'h0;
         o_axi_lite_bready  <= 1'b0;
         o_axi_lite_arvalid <= 1'b0;
         o_axi_lite_araddr  <= '0;
         o_axi_lite_rready  <= 1'b0;
      end else begin
         o_wr_done <= 1'b0;
         o_rd_done <= 1'b0;
         o_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (i_wr_go) begin
                  o_axi_lite_awaddr  <= i_wr_addr;
                  o_axi_lite_wdata   <= i_wr_data;
                  o_axi_lite_wstrb   <= i_wr_strb;
                  o_axi_lite_awvalid <= 1'b1;
                  o_axi_lite_wvalid  <= 1'b1;
                  aw_done            <= 1'b0;
                  w_done             <= 1'b0;
                  rd_pend            <= i_rd_go;
                  if (i_rd_go) o_axi_lite_araddr <= i_rd_addr;
                  o_busy             <= 1'b1;
                  state              <= WADDR;
               end else if (i_rd_go) begin
                  o_axi_lite_araddr  <= i_rd_addr;
                  o_axi_lite_arvalid <= 1'b1;
                  o_busy             <= 1'b1;
                  state              <= RADDR;
               end
            end
            WADDR: begin
               // AW and W retire independently; B is opened once both are in.
               if (aw_hs) begin
                  o_axi_lite_awvalid <= 1'b0;
                  aw_done            <= 1'b1;
               end
               if (w_hs) begin
                  o_axi_lite_wvalid <= 1'b0;
                  w_done            <= 1'b1;
               end
               if (aw_fin && w_fin) begin
                  o_axi_lite_bready <= 1'b1;
                  wait_cnt          <= '0;
                  state             <= WRESP;
               end
            end
            WRESP: begin
               if (b_hs || to_hit) begin
                  o_axi_lite_bready <= 1'b0;
                  o_wr_done         <= 1'b1;
                  o_bresp           <= b_hs ? i_axi_lite_bresp : 2'b11;
                  o_timeout         <= ~b_hs;
                  // A read accepted together with this write runs even if the write aborted.
                  if (rd_pend) begin
                     rd_pend            <= 1'b0;
                     o_axi_lite_arvalid <= 1'b1;
                     state              <= RADDR;
                  end else begin
                     o_busy <= 1'b0;
                     state  <= IDLE;
                  end
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            RADDR: begin
               if (ar_hs) begin
                  o_axi_lite_arvalid <= 1'b0;
                  o_axi_lite_rready  <= 1'b1;
                  wait_cnt           <= '0;
                  state              <= RRESP;
               end
            end
            RRESP: begin
               if (r_hs || to_hit) begin
                  o_axi_lite_rready <= 1'b0;
                  o_rd_done         <= 1'b1;
                  o_rresp           <= r_hs ? i_axi_lite_rresp : 2'b11;
                  o_timeout         <= ~r_hs;
                  if (r_hs) o_rdata <= i_axi_lite_rdata;
                  o_busy            <= 1'b0;
                  state             <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            default: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
